// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   REG_ADDR_W / REG_ZERO : register address width and the hard-wired zero register
//   grant_e               : which source owns the write port in a given cycle
//   addr_hit()            : pending-write match used for hazard flags
package writeback_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LNG
  } grant_e;

  // r0 never counts as a pending write target.
  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] entry_addr,
                                    input logic [REG_ADDR_W-1:0] chk_addr);
    return (chk_addr != REG_ZERO) && (entry_addr == chk_addr);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for long-latency writeback results.
//   clk, rst    : clock, synchronous active-high reset (flushes contents)
//   push        : enqueue push_data (ignored when full)
//   push_data   : entry to enqueue
//   pop         : dequeue head (ignored when empty)
//   head        : current head entry
//   full, empty : occupancy flags
//   count       : number of valid entries
//   entries     : raw storage, for external address compares
//   valid       : per-slot flag, set for slots holding a queued entry
module wb_fifo #(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [W-1:0]                    push_data,
  input  logic                            pop,
  output logic [W-1:0]                    head,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH):0]          count,
  output logic [DEPTH-1:0][W-1:0]         entries,
  output logic [DEPTH-1:0]                valid
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Slot i is live when its distance from the read pointer (mod DEPTH) is below count.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PW'(PW'(i) - rd_ptr)} < count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port.
// ALU has priority and never waits; long-source results queue in wb_fifo.
//   clk, rst            : clock, synchronous active-high reset
//   alu_valid/addr/data : single-cycle ALU result
//   lng_valid/addr/data : long-source result, handshaked with lng_ready
//   lng_ready           : FIFO has room (low during reset)
//   chk_addr0/1         : source registers to test against queued writes
//   busy0/1             : chk_addr matches a queued write (combinational)
//   alu_stall           : core must hold alu_valid low next cycle (registered)
//   wr_ena/addr/data    : registered register-file write port
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_STARVE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [N-1:0]          alu_data,
  input  logic                  lng_valid,
  output logic                  lng_ready,
  input  logic [REG_ADDR_W-1:0] lng_addr,
  input  logic [N-1:0]          lng_data,
  input  logic [REG_ADDR_W-1:0] chk_addr0,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  output logic                  busy0,
  output logic                  busy1,
  output logic                  alu_stall,
  output logic                  wr_ena,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [N-1:0]          wr_data
);

  localparam int unsigned EW = N + REG_ADDR_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(MAX_STARVE) + 1;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [EW-1:0]           fifo_head;
  logic [DEPTH-1:0][EW-1:0] fifo_entries;
  logic [DEPTH-1:0]        fifo_valid;

  grant_e                  grant;
  logic [SW-1:0]           starve_cnt;
  logic                    starve_hit;
  logic                    alu_waw;

  assign lng_ready = !rst && !fifo_full;
  // r0 results complete the handshake but are never queued.
  assign fifo_push = lng_valid && lng_ready && (lng_addr != REG_ZERO);

  wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({lng_addr, lng_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .entries   (fifo_entries),
    .valid     (fifo_valid)
  );

  always_comb begin
    grant = GNT_NONE;
    if (alu_valid && (alu_addr != REG_ZERO)) begin
      grant = GNT_ALU;
    end else if (!fifo_empty) begin
      grant = GNT_LNG;
    end
  end

  assign fifo_pop = (grant == GNT_LNG);

  // The entry popped this cycle still flags busy until its write lands.
  always_comb begin
    busy0   = 1'b0;
    busy1   = 1'b0;
    alu_waw = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) begin
        busy0   = busy0   | addr_hit(fifo_entries[i][EW-1:N], chk_addr0);
        busy1   = busy1   | addr_hit(fifo_entries[i][EW-1:N], chk_addr1);
        alu_waw = alu_waw | addr_hit(fifo_entries[i][EW-1:N], alu_addr);
      end
    end
  end

  // Counter saturates at MAX_STARVE so the stall holds while the ALU keeps winning.
  assign starve_hit = !fifo_empty && !fifo_pop && (starve_cnt >= SW'(MAX_STARVE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else begin
      if (fifo_empty || fifo_pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(MAX_STARVE)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      alu_stall <= starve_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ena  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_ena <= (grant != GNT_NONE);
      case (grant)
        GNT_ALU: begin
          wr_addr <= alu_addr;
          wr_data <= alu_data;
        end
        GNT_LNG: begin
          wr_addr <= fifo_head[EW-1:N];
          wr_data <= fifo_head[N-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(alu_valid && alu_waw));
      assert (fifo_count <= CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int N          = 32;
  localparam int DEPTH      = 4;
  localparam int MAX_STARVE = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [4:0]    alu_addr  = '0;
  logic [N-1:0]  alu_data  = '0;
  logic          lng_valid = 1'b0;
  logic          lng_ready;
  logic [4:0]    lng_addr  = '0;
  logic [N-1:0]  lng_data  = '0;
  logic [4:0]    chk_addr0 = '0;
  logic [4:0]    chk_addr1 = '0;
  logic          busy0, busy1, alu_stall, wr_ena;
  logic [4:0]    wr_addr;
  logic [N-1:0]  wr_data;

  writeback_arbiter #(
    .N          (N),
    .DEPTH      (DEPTH),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .lng_valid (lng_valid),
    .lng_ready (lng_ready),
    .lng_addr  (lng_addr),
    .lng_data  (lng_data),
    .chk_addr0 (chk_addr0),
    .chk_addr1 (chk_addr1),
    .busy0     (busy0),
    .busy1     (busy1),
    .alu_stall (alu_stall),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending long-source writes plus expected port state.
  typedef struct {
    logic [4:0]   addr;
    logic [N-1:0] data;
  } ent_t;

  ent_t         q[$];
  logic         m_ena   = 1'b0;
  logic [4:0]   m_addr  = '0;
  logic [N-1:0] m_data  = '0;
  logic         m_stall = 1'b0;
  int           m_wait  = 0;
  bit           hs_last = 1'b0;
  bit           seen_stall = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check combinational outputs against the model, advance the model,
  // then check the registered outputs after the edge.
  task automatic tick();
    bit   rdy, alu_go, pop;
    ent_t e;
    #1;
    rdy = !rst && (q.size() < DEPTH);
    check("lng_ready", N'(lng_ready), N'(rdy));
    if (!rst) begin
      check("busy0", N'(busy0), N'(pending(chk_addr0)));
      check("busy1", N'(busy1), N'(pending(chk_addr1)));
    end
    hs_last = 1'b0;
    if (rst) begin
      q.delete();
      m_ena = 0; m_addr = '0; m_data = '0; m_stall = 0; m_wait = 0;
    end else begin
      alu_go = alu_valid && (alu_addr != 5'd0);
      pop    = !alu_go && (q.size() != 0);
      if (alu_go) begin
        m_ena = 1; m_addr = alu_addr; m_data = alu_data;
      end else if (pop) begin
        m_ena = 1; m_addr = q[0].addr; m_data = q[0].data;
      end else begin
        m_ena = 0;
      end
      if (q.size() == 0 || pop) begin
        m_wait = 0; m_stall = 0;
      end else begin
        m_stall = (m_wait >= MAX_STARVE - 1);
        m_wait++;
      end
      if (pop) e = q.pop_front();
      hs_last = lng_valid && rdy;
      if (hs_last && lng_addr != 5'd0) begin
        e.addr = lng_addr; e.data = lng_data;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("wr_ena",    N'(wr_ena),    N'(m_ena));
    check("wr_addr",   N'(wr_addr),   N'(m_addr));
    check("wr_data",   wr_data,       m_data);
    check("alu_stall", N'(alu_stall), N'(m_stall));
    if (alu_stall) seen_stall = 1'b1;
  endtask

  task automatic idle();
    alu_valid = 0; lng_valid = 0;
  endtask

  initial begin
    int n;
    logic [4:0] a;

    // Reset held three cycles.
    rst = 1;
    for (int i = 0; i < 3; i++) tick();
    rst = 0;
    tick();

    // ALU alone.
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    check("t2_addr", N'(wr_addr), 32'd5);
    check("t2_data", wr_data, 32'hDEADBEEF);
    idle();
    tick();

    // ALU and long source in the same cycle; busy on r7 until its write lands.
    alu_valid = 1; alu_addr = 5'd3; alu_data = 32'h33;
    lng_valid = 1; lng_addr = 5'd7; lng_data = 32'h77;
    chk_addr0 = 5'd7; chk_addr1 = 5'd3;
    tick();
    check("t3_r3", N'(wr_addr), 32'd3);
    idle();
    tick();
    check("t3_r7", N'(wr_addr), 32'd7);
    tick();

    // r0 handling.
    lng_valid = 1; lng_addr = 5'd0; lng_data = 32'h0BAD;
    tick();
    lng_valid = 0;
    tick();
    alu_valid = 1; alu_addr = 5'd10; alu_data = 32'hA;
    lng_valid = 1; lng_addr = 5'd9; lng_data = 32'h99;
    chk_addr0 = 5'd9;
    tick();
    lng_valid = 0; alu_valid = 1; alu_addr = 5'd0; alu_data = 32'h1;
    tick();
    check("t4_r9", N'(wr_addr), 32'd9);
    idle();
    tick();

    // Fill past capacity while the ALU hogs the port, then drain.
    seen_stall = 0;
    n = 1;
    chk_addr0 = 5'd1; chk_addr1 = 5'd6;
    for (int c = 0; c < 14; c++) begin
      alu_valid = 1; alu_addr = 5'(16 + c % 8); alu_data = $urandom;
      lng_valid = (n <= 6); lng_addr = 5'(n); lng_data = 32'h1000 + n;
      tick();
      if (hs_last) n++;
    end
    check("t5_full_after4", N'(n), 32'd5);
    check("t5_stall_seen", N'(seen_stall), 32'd1);
    alu_valid = 0;
    for (int c = 0; c < 12; c++) begin
      lng_valid = (n <= 6); lng_addr = 5'(n); lng_data = 32'h1000 + n;
      tick();
      if (hs_last) n++;
    end
    check("t5_all_pushed", N'(n), 32'd7);
    idle();

    // Reset with three entries queued.
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_addr = 5'(20 + c); alu_data = $urandom;
      lng_valid = 1; lng_addr = 5'(11 + c); lng_data = $urandom;
      tick();
    end
    idle();
    chk_addr0 = 5'd11; chk_addr1 = 5'd13;
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 4; c++) tick();
    check("t6_busy0", N'(busy0), 32'd0);
    check("t6_ena", N'(wr_ena), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      alu_valid = ($urandom_range(0, 1) == 1);
      if (m_stall && $urandom_range(0, 3) != 0) alu_valid = 0;
      a = 5'd0;
      for (int t = 0; t < 8; t++) begin
        a = 5'($urandom_range(0, 31));
        if (!pending(a)) break;
        a = 5'd0;
      end
      alu_addr  = a;
      alu_data  = $urandom;
      lng_valid = ($urandom_range(0, 1) == 1);
      lng_addr  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) lng_addr = 5'd0;
      lng_data  = $urandom;
      chk_addr0 = (q.size() != 0 && $urandom_range(0, 1) == 1) ? q[$urandom_range(0, q.size() - 1)].addr
                                                              : 5'($urandom_range(0, 31));
      chk_addr1 = 5'($urandom_range(0, 31));
      tick();
    end
    rst = 0;
    idle();
    for (int c = 0; c < 10; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
